vend_dispenser: RTL

VEND_DISPENSER -- requirements
Module: vend_dispenser

---
 rtl/vend_dispenser.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/vend_dispenser.sv
// vend_dispenser: soda / diet / nickel-return actuator sequencer.
// Requests are latched as pending records. One actuator pulse of PULSE_CYC cycles
// is issued at a time, chosen by fixed priority, and each pulse is followed by
// GAP_CYC idle cycles.
// Optional build macro CHANGE_SAT_EN: owed saturates at 15 and a sticky overflow
// flag is raised. Without it, owed wraps and overflow stays 0.
module vend_dispenser #(
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       giveSoda,
  input  logic       giveDiet,
  input  logic       change,
  output logic       motorSoda,
  output logic       motorDiet,
  output logic       coinOut,
  output logic       busy,
  output logic [3:0] owed,
  output logic       overflow
);

  typedef enum logic [2:0] {IDLE, SODA, DIET, COIN, GAP} state_t;

  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] GAP_LD   = 4'(GAP_CYC - 1);

  state_t     state_q, state_d, dispatch;
  logic [3:0] cnt_q, cnt_d;
  logic       pend_soda_q, pend_soda_d;
  logic       pend_diet_q, pend_diet_d;
  logic [3:0] owed_q, owed_d;
  logic       overflow_q, overflow_d;
  logic       motor_soda_q, motor_soda_d;
  logic       motor_diet_q, motor_diet_d;
  logic       coin_out_q, coin_out_d;
  logic       enter_soda, enter_diet, enter_coin;

  // Fixed-priority choice of the next pulse, from registered pending state
  always_comb begin
    dispatch = IDLE;
    if (pend_soda_q)          dispatch = SODA;
    else if (pend_diet_q)     dispatch = DIET;
    else if (owed_q != '0)    dispatch = COIN;
  end

  // Next-state and pulse/gap counter.
  // The final GAP edge makes the IDLE dispatch decision itself. Back-to-back
  // pulses are therefore separated by exactly GAP_CYC low cycles. The FSM
  // still settles in IDLE when nothing is pending.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        state_d = dispatch;
        cnt_d   = PULSE_LD;
      end
      SODA, DIET, COIN: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = dispatch;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pending records, the owed counter, and the registered actuator drives
  always_comb begin
    enter_soda = (state_d == SODA) && (state_q != SODA);
    enter_diet = (state_d == DIET) && (state_q != DIET);
    enter_coin = (state_d == COIN) && (state_q != COIN);

    // A strobe arriving on the same edge that consumes the flag keeps it set
    pend_soda_d = giveSoda | (pend_soda_q & ~enter_soda);
    pend_diet_d = giveDiet | (pend_diet_q & ~enter_diet);

    owed_d     = owed_q;
    overflow_d = 1'b0;
    unique case ({change, enter_coin})
`ifdef CHANGE_SAT_EN
      2'b10:   owed_d = (owed_q == 4'hF) ? owed_q : owed_q + 4'd1;
`else
      2'b10:   owed_d = owed_q + 4'd1;
`endif
      2'b01:   owed_d = owed_q - 4'd1;
      default: owed_d = owed_q;
    endcase
`ifdef CHANGE_SAT_EN
    overflow_d = overflow_q | (change & (owed_q == 4'hF));
`endif

    motor_soda_d = (state_d == SODA);
    motor_diet_d = (state_d == DIET);
    coin_out_d   = (state_d == COIN);
  end

  // State register with synchronous active-high reset
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_soda_q  <= 1'b0;
      pend_diet_q  <= 1'b0;
      owed_q       <= '0;
      overflow_q   <= 1'b0;
      motor_soda_q <= 1'b0;
      motor_diet_q <= 1'b0;
      coin_out_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_soda_q  <= pend_soda_d;
      pend_diet_q  <= pend_diet_d;
      owed_q       <= owed_d;
      overflow_q   <= overflow_d;
      motor_soda_q <= motor_soda_d;
      motor_diet_q <= motor_diet_d;
      coin_out_q   <= coin_out_d;
    end
  end

  assign motorSoda = motor_soda_q;
  assign motorDiet = motor_diet_q;
  assign coinOut   = coin_out_q;
  assign owed      = owed_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != IDLE) | pend_soda_q | pend_diet_q | (owed_q != '0);

endmodule
